// File: rtl/text_ram_loader_if.sv
// Byte-stream and text-RAM write-port bundle for text_ram_loader.
//   byte_valid, byte_data : byte source -> loader
//   byte_ready            : loader -> byte source (transfer = byte_valid & byte_ready)
//   mem_we/waddr/wdata    : loader -> text RAM write port
// The master modport is the loader. The slave modport is the source/RAM side.
interface text_ram_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/text_ram_loader.sv
// Text RAM loader.
// Takes a byte stream made of a 16-bit little-endian word count N followed by 4*N payload bytes.
// It packs the payload into little-endian 32-bit words and writes them to consecutive text RAM
// addresses, starting at 0. The CPU is held in reset while a session is active.
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   load_start : one-cycle pulse that starts or restarts a session
//   bus        : byte stream in and text RAM write port out (text_ram_loader_if.master)
//   cpu_hold   : holds the CPU/PC in reset while loading
//   busy       : session active
//   done       : session finished, sticky until the next load_start or rst
//   err        : session ended abnormally (overflow or bad checksum), sticky like done
//
// Optional feature: define TEXT_LOADER_CHECKSUM_EN to expect one trailing byte.
// That byte is the XOR of all payload bytes.
module text_ram_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  text_ram_loader_if.master   bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

`ifdef TEXT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StData, StDone, StCksum} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StData, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic [7:0]            lo_q, lo_d;        // CNT_LO held until CNT_HI arrives
  logic [15:0]           n_q, n_d;          // word count N
  logic [16:0]           cnt_q, cnt_d;      // words consumed so far; no wrap at Depth
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           buf_q, buf_d;      // first three bytes of the current word
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
`ifdef TEXT_LOADER_CHECKSUM_EN
  logic [7:0]            acc_q, acc_d;
`endif

  logic active, xfer, overflow;

`ifdef TEXT_LOADER_CHECKSUM_EN
  assign active = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData) ||
                  (state_q == StCksum);
`else
  assign active = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
`endif
  assign xfer     = bus.byte_valid & active;
  assign overflow = 32'(n_q) > Depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lo_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef TEXT_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef TEXT_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef TEXT_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    if (load_start) begin
      // Restart wins over any byte in the same cycle. A partial word is dropped.
      state_d = StHdr0;
      cnt_d   = '0;
      lane_d  = '0;
      err_d   = 1'b0;
`ifdef TEXT_LOADER_CHECKSUM_EN
      acc_d   = '0;
`endif
    end else if (xfer) begin
      unique case (state_q)
        StHdr0: begin
          lo_d    = bus.byte_data;
          state_d = StHdr1;
        end
        StHdr1: begin
          n_d = {bus.byte_data, lo_q};
          if ({bus.byte_data, lo_q} == 16'd0) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
            state_d = StCksum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
        StData: begin
`ifdef TEXT_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ bus.byte_data;
`endif
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: buf_d[7:0]   = bus.byte_data;
            2'd1: buf_d[15:8]  = bus.byte_data;
            2'd2: buf_d[23:16] = bus.byte_data;
            2'd3: begin
              // Words past the end of the RAM are consumed but not written.
              if (32'(cnt_q) < Depth) begin
                we_d    = 1'b1;
                waddr_d = cnt_q[ADDR_WIDTH-1:0];
                wdata_d = {bus.byte_data, buf_q};
              end
              cnt_d = cnt_q + 17'd1;
              if (cnt_q + 17'd1 == {1'b0, n_q}) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
                state_d = StCksum;
`else
                state_d = StDone;
                err_d   = overflow;
`endif
              end
            end
            default: ;
          endcase
        end
`ifdef TEXT_LOADER_CHECKSUM_EN
        StCksum: begin
          err_d   = overflow | (bus.byte_data != acc_q);
          state_d = StDone;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = active;
  assign bus.mem_we     = we_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = active;
  assign cpu_hold       = active;
  assign done           = (state_q == StDone);
  assign err            = err_q;

endmodule

// File: tb/tb_text_ram_loader.sv
module tb_text_ram_loader;
  localparam int unsigned AW = 2;
`ifdef TEXT_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0;
  logic cpu_hold, busy, done, err;

  always #5 clk = ~clk;

  text_ram_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

  text_ram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int               nb;
    logic [0:23][7:0] b;
    int               nw;
    logic [31:0]      w [4];
    bit               err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stalls = 0;
  logic [7:0]    stream [$];
  int            xfer_cyc [$];
  int            wr_cyc [$];
  logic [31:0]   wr_data [$];
  logic [AW-1:0] wr_addr [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_cyc.push_back(cyc);
      wr_data.push_back(bus.mem_wdata);
      wr_addr.push_back(bus.mem_waddr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    stream.delete();
    xfer_cyc.delete();
    wr_cyc.delete();
    wr_data.delete();
    wr_addr.delete();
    stalls = 0;
  endtask

  // Ends on a negedge with the loader in HDR0.
  task automatic pulse_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    clear_logs();
  endtask

  // Called on a negedge. Keeps byte_valid high across back-to-back bytes.
  task automatic send_stream();
    foreach (stream[i]) begin
      int t = 0;
      while (!bus.byte_ready && t < 20) begin
        @(negedge clk);
        t++;
        stalls++;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = stream[i];
      xfer_cyc.push_back(cyc + 1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < v.nb; k++) begin
      stream.push_back(v.b[k]);
      if (k >= 2) x = x ^ v.b[k];
    end
    if (CkEn) stream.push_back(x);
    send_stream();
  endtask

  task automatic finish_check(input string tag, input vec_t v);
    int t = 0;
    while (!done && t < 10) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk($sformatf("%s done", tag), 32'(done), 32'd1);
    chk($sformatf("%s busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s cpu_hold", tag), 32'(cpu_hold), 32'd0);
    chk($sformatf("%s byte_ready", tag), 32'(bus.byte_ready), 32'd0);
    chk($sformatf("%s err", tag), 32'(err), 32'(v.err));
    chk($sformatf("%s stalls", tag), 32'(stalls), 32'd0);
    chk($sformatf("%s nwrites", tag), 32'(wr_data.size()), 32'(v.nw));
    for (int j = 0; j < v.nw; j++) begin
      if (j < wr_data.size()) begin
        chk($sformatf("%s waddr%0d", tag, j), 32'(wr_addr[j]), 32'(j));
        chk($sformatf("%s wdata%0d", tag, j), wr_data[j], v.w[j]);
        if (2 + 4 * j + 3 < xfer_cyc.size())
          chk($sformatf("%s latency%0d", tag, j), 32'(wr_cyc[j]), 32'(xfer_cyc[2 + 4 * j + 3]));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s mem_we", tag), 32'(bus.mem_we), 32'd0);
    chk($sformatf("%s mem_waddr", tag), 32'(bus.mem_waddr), 32'd0);
    chk($sformatf("%s mem_wdata", tag), bus.mem_wdata, 32'd0);
    chk($sformatf("%s byte_ready", tag), 32'(bus.byte_ready), 32'd0);
    chk($sformatf("%s busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s done", tag), 32'(done), 32'd0);
    chk($sformatf("%s err", tag), 32'(err), 32'd0);
    chk($sformatf("%s cpu_hold", tag), 32'(cpu_hold), 32'd0);
  endtask

  vec_t vecs [5];
  vec_t h;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Boot program from the basic scenario.
    vecs[0].nb = 10;
    vecs[0].b[0:9] = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    vecs[0].nw = 2;
    vecs[0].w = '{32'h00500013, 32'h0000006F, 32'h0, 32'h0};
    vecs[0].err = 1'b0;
    // Empty image.
    vecs[1].nb = 2;
    vecs[1].b[0:1] = {8'h00, 8'h00};
    vecs[1].nw = 0;
    vecs[1].w = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1].err = 1'b0;
    // Three words, back to back.
    vecs[2].nb = 14;
    vecs[2].b[0:13] = {8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                       8'hCC, 8'hBB, 8'hAA, 8'h99};
    vecs[2].nw = 3;
    vecs[2].w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0};
    vecs[2].err = 1'b0;
    // N=5 into a 4-word RAM: fifth word dropped, err set.
    vecs[3].nb = 22;
    vecs[3].b[0:21] = {8'h05, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                       8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
                       8'h05, 8'h00, 8'h00, 8'h00};
    vecs[3].nw = 4;
    vecs[3].w = '{32'h1, 32'h2, 32'h3, 32'h4};
    vecs[3].err = 1'b1;
    // N equal to depth: fills the RAM, no error.
    vecs[4].nb = 18;
    vecs[4].b[0:17] = {8'h04, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B,
                       8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[4].nw = 4;
    vecs[4].w = '{32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'hFFFFFFFF};
    vecs[4].err = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Bytes offered in IDLE are ignored.
    clear_logs();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("idle byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle nwrites", 32'(wr_data.size()), 32'd0);

    for (int i = 0; i < 5; i++) begin
      pulse_load();
      chk($sformatf("v%0d busy_hdr", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d cpu_hold_hdr", i), 32'(cpu_hold), 32'd1);
      apply_vec(vecs[i]);
      finish_check($sformatf("v%0d", i), vecs[i]);
    end

    // Abort after two payload bytes, then a fresh one-word image.
    pulse_load();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_stream();
    chk("abort busy_mid", 32'(busy), 32'd1);
    pulse_load();
    h.nb = 6;
    h.b[0:5] = {8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    h.nw = 1;
    h.w = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    h.err = 1'b0;
    apply_vec(h);
    finish_check("abort", h);

    // load_start together with a byte in HDR0: the byte is dropped.
    pulse_load();
    load_start = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h03;
    @(negedge clk);
    load_start = 1'b0;
    bus.byte_valid = 1'b0;
    clear_logs();
    h.nb = 6;
    h.b[0:5] = {8'h01, 8'h00, 8'hFE, 8'hCA, 8'hAD, 8'h0B};
    h.nw = 1;
    h.w = '{32'h0BADCAFE, 32'h0, 32'h0, 32'h0};
    h.err = 1'b0;
    apply_vec(h);
    finish_check("ls_byte", h);

    // rst mid-word after one completed write.
    pulse_load();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h11, 8'h22};
    send_stream();
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h33;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    #1;
    chk("rst_mid nwrites", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() > 0) chk("rst_mid wdata0", wr_data[0], 32'h12345678);
    chk("rst_mid busy_after", 32'(busy), 32'd0);
    chk("rst_mid cpu_hold_after", 32'(cpu_hold), 32'd0);

`ifdef TEXT_LOADER_CHECKSUM_EN
    // Correct trailing checksum: 01^02^04^08 = 0F.
    h.nb = 6;
    h.b[0:5] = {8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08};
    h.nw = 1;
    h.w = '{32'h08040201, 32'h0, 32'h0, 32'h0};
    h.err = 1'b0;
    pulse_load();
    stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    send_stream();
    finish_check("ck_good", h);
    // Wrong trailing checksum.
    h.err = 1'b1;
    pulse_load();
    stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    send_stream();
    finish_check("ck_bad", h);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
